// File: rtl/bus_xact_ctrl.sv
// bus_xact_ctrl: single-outstanding command-to-slave transaction controller with ack timeout
// Ports: clock, reset (async, active-high); cmd_* upstream command handshake;
//        rsp_* upstream response handshake; slv_* registered one-hot request to the slaves
//        with per-slave ack/rdata back; xact_count/err_count completed and timed-out totals.
module bus_xact_ctrl #(
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [7:0]              cmd_addr,
   input  logic [7:0]              cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [7:0]              rsp_rdata,
   output logic                    rsp_err,
   output logic [NUM_SLAVES-1:0]   slv_sel,
   output logic                    slv_write,
   output logic [7:0]              slv_addr,
   output logic [7:0]              slv_wdata,
   input  logic [NUM_SLAVES-1:0]   slv_ack,
   input  logic [NUM_SLAVES*8-1:0] slv_rdata,
   output logic [15:0]             xact_count,
   output logic [7:0]              err_count
);
   localparam int SW = $clog2(NUM_SLAVES);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t     state;
   logic [7:0] timer;
   logic [7:0] sel_rdata;
   logic       ack;
   // slv_sel is one-hot while in REQ, so it doubles as the read-data mux select
   always_comb begin
      sel_rdata = '0;
      for (int k = 0; k < NUM_SLAVES; k++) sel_rdata = slv_sel[k] ? slv_rdata[8*k +: 8] : sel_rdata;
   end
   assign ack = |(slv_ack & slv_sel);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         slv_sel    <= '0;
         slv_write  <= 1'b0;
         slv_addr   <= '0;
         slv_wdata  <= '0;
         timer      <= '0;
         xact_count <= '0;
         err_count  <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               state     <= REQ;
               cmd_ready <= 1'b0;
               slv_sel   <= NUM_SLAVES'(1) << cmd_addr[7 -: SW];
               slv_write <= cmd_write;
               slv_addr  <= cmd_addr;
               slv_wdata <= cmd_wdata;
               timer     <= '0;
            end
            // an ack on the timeout cycle still counts as a successful completion
            REQ: if (ack || timer == 8'(TIMEOUT - 1)) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= !ack;
               rsp_rdata <= (ack && !slv_write) ? sel_rdata : '0;
               slv_sel   <= '0;
               slv_write <= 1'b0;
            end else begin
               timer <= timer + 8'd1;
            end
            RESP: if (rsp_ready) begin
               state      <= IDLE;
               rsp_valid  <= 1'b0;
               cmd_ready  <= 1'b1;
               xact_count <= xact_count + 16'd1;
               if (rsp_err && err_count != 8'hff) err_count <= err_count + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_xact_ctrl.sv
// tb_bus_xact_ctrl: randomized self-checking bench for bus_xact_ctrl against a per-transaction outcome model
module tb_bus_xact_ctrl;
   localparam int NS = 4;
   localparam int TO = 16;
   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [7:0]    cmd_addr = '0;
   logic [7:0]    cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [7:0]    rsp_rdata;
   logic          rsp_err;
   logic [NS-1:0] slv_sel;
   logic          slv_write;
   logic [7:0]    slv_addr;
   logic [7:0]    slv_wdata;
   logic [NS-1:0] slv_ack = '0;
   logic [NS*8-1:0] slv_rdata = '0;
   logic [15:0]   xact_count;
   logic [7:0]    err_count;
   int n_tests = 0;
   int n_fail = 0;
   int exp_x = 0;
   int exp_e = 0;
   always #5 clock = ~clock;
   bus_xact_ctrl #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .slv_sel(slv_sel), .slv_write(slv_write), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
      .slv_ack(slv_ack), .slv_rdata(slv_rdata),
      .xact_count(xact_count), .err_count(err_count)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   // One command end to end: ack_n is the REQ cycle in which the selected slave acks
   // (beyond TO means it never does), hold is the number of cycles rsp_ready stays low.
   task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d, input int ack_n,
                       input int hold, input bit keep, input bit fix, input logic [7:0] fv);
      logic [NS-1:0] oh;
      logic [7:0]    erd;
      logic          eerr;
      int            idx;
      int            k;
      idx = int'(a[7:6]);
      oh = NS'(1) << idx;
      erd = '0;
      eerr = 1'b1;
      cmd_write = w;
      cmd_addr = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 50) begin
         step;
         k++;
      end
      chk("ready_wait", 32'(k < 50), 1);
      step;
      if (!keep) cmd_valid = 1'b0;
      for (int n = 1; n <= TO; n++) begin
         chk("sel", 32'(slv_sel), 32'(oh));
         chk("slv_write", 32'(slv_write), 32'(w));
         chk("slv_addr", 32'(slv_addr), 32'(a));
         chk("slv_wdata", 32'(slv_wdata), 32'(d));
         chk("rsp_valid_req", 32'(rsp_valid), 0);
         chk("cmd_ready_req", 32'(cmd_ready), 0);
         slv_rdata = (NS*8)'($urandom);
         if (fix) slv_rdata[8*idx +: 8] = fv;
         slv_ack = NS'($urandom) & ~oh;
         if (n == ack_n) begin
            slv_ack = slv_ack | oh;
            erd = w ? 8'h00 : slv_rdata[8*idx +: 8];
            eerr = 1'b0;
         end
         step;
         if (n == ack_n) break;
      end
      slv_ack = '0;
      for (int h = 0; h <= hold; h++) begin
         chk("rsp_valid", 32'(rsp_valid), 1);
         chk("rsp_rdata", 32'(rsp_rdata), 32'(erd));
         chk("rsp_err", 32'(rsp_err), 32'(eerr));
         chk("sel_resp", 32'(slv_sel), 0);
         chk("slv_write_resp", 32'(slv_write), 0);
         chk("cmd_ready_resp", 32'(cmd_ready), 0);
         rsp_ready = (h == hold);
         step;
      end
      rsp_ready = 1'b0;
      exp_x = (exp_x + 1) % 65536;
      if (eerr && exp_e < 255) exp_e++;
      chk("rsp_valid_idle", 32'(rsp_valid), 0);
      chk("cmd_ready_idle", 32'(cmd_ready), 1);
      chk("sel_idle", 32'(slv_sel), 0);
      chk("xact_count", 32'(xact_count), 32'(exp_x));
      chk("err_count", 32'(err_count), 32'(exp_e));
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      #12;
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_sel", 32'(slv_sel), 0);
      chk("rst_slv_write", 32'(slv_write), 0);
      chk("rst_slv_addr", 32'(slv_addr), 0);
      chk("rst_slv_wdata", 32'(slv_wdata), 0);
      chk("rst_xact_count", 32'(xact_count), 0);
      chk("rst_err_count", 32'(err_count), 0);
      reset = 1'b0;
      step;
      xact(1'b1, 8'h45, 8'hA5, 3, 0, 1'b0, 1'b0, 8'h00);
      xact(1'b0, 8'hC0, 8'h00, 1, 0, 1'b0, 1'b1, 8'h5C);
      xact(1'b0, 8'h10, 8'h00, TO + 1, 1, 1'b0, 1'b0, 8'h00);
      xact(1'b0, 8'h7F, 8'h00, TO, 0, 1'b0, 1'b1, 8'h3E);
      xact(1'b1, 8'h99, 8'h3C, 2, 5, 1'b1, 1'b0, 8'h00);
      xact(1'b1, 8'h99, 8'h3C, 1, 0, 1'b0, 1'b0, 8'h00);
      cmd_write = 1'b0;
      cmd_addr = 8'h80;
      cmd_valid = 1'b1;
      step;
      cmd_valid = 1'b0;
      chk("abort_sel_before", 32'(slv_sel), 32'h4);
      step;
      #2 reset = 1'b1;
      #1;
      chk("abort_sel", 32'(slv_sel), 0);
      chk("abort_cmd_ready", 32'(cmd_ready), 1);
      chk("abort_rsp_valid", 32'(rsp_valid), 0);
      #2 reset = 1'b0;
      exp_x = 0;
      exp_e = 0;
      step;
      step;
      chk("abort_no_rsp", 32'(rsp_valid), 0);
      chk("abort_idle_sel", 32'(slv_sel), 0);
      chk("abort_xact_count", 32'(xact_count), 0);
      chk("abort_err_count", 32'(err_count), 0);
      for (int i = 0; i < 60; i++)
         xact(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(1, TO + 2)),
              int'($urandom_range(0, 3)), 1'b0, 1'b0, 8'h00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_xact_ctrl.md
BUS_XACT_CTRL -- requirements
Module: bus_xact_ctrl

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of slave ports; power of two, 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for a slave ack; range 1..255.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous reset, active-high.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  8  command address.
REQ-009 cmd_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  upstream accepts the response.
REQ-012 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  transaction timed out.
REQ-014 slv_sel  output  NUM_SLAVES  one-hot slave select.
REQ-015 slv_write  output  1  write strobe qualifier to the selected slave.
REQ-016 slv_addr  output  8  address to slaves; the full cmd_addr.
REQ-017 slv_wdata  output  8  write data to slaves.
REQ-018 slv_ack  input  NUM_SLAVES  per-slave completion acknowledge.
REQ-019 slv_rdata  input  NUM_SLAVES*8  per-slave read data; slave k occupies bits [8k+7:8k].
REQ-020 xact_count  output  16  completed-transaction counter.
REQ-021 err_count  output  8  timed-out-transaction counter.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-023 In IDLE, cmd_ready SHALL be 1; in REQ and RESP it SHALL be 0.
REQ-024 In IDLE, a cycle with cmd_valid=1 SHALL capture cmd_write, cmd_addr and cmd_wdata, clear the timer and move to REQ.
REQ-025 Slave index SHALL be cmd_addr[7:8-log2(NUM_SLAVES)]; with NUM_SLAVES=4 this is addr[7:6].
REQ-026 All slv_* outputs SHALL be registered.
REQ-027 In REQ, slv_sel SHALL be one-hot on the decoded index, and slv_write, slv_addr and slv_wdata SHALL hold the captured values.
REQ-028 Outside REQ, slv_sel and slv_write SHALL be 0.
REQ-029 slv_sel SHALL first assert in the cycle after acceptance.
REQ-030 In REQ, slv_ack of the selected slave SHALL end the transaction: rsp_rdata <= slv_rdata[index] for reads (0 for writes), rsp_err <= 0, next state RESP.
REQ-031 slv_ack bits of non-selected slaves SHALL be ignored.
REQ-032 The timer SHALL increment in each REQ cycle without a valid ack.
REQ-033 When the timer equals TIMEOUT-1 with no ack, the transaction SHALL end with rsp_err <= 1, rsp_rdata <= 0, next state RESP, so slv_sel is high exactly TIMEOUT cycles.
REQ-034 An ack arriving in the same cycle as the timeout condition SHALL win: no error.
REQ-035 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be stable until rsp_ready=1; that cycle SHALL return to IDLE.
REQ-036 A new command SHALL not be accepted in the RESP-exit cycle.
REQ-037 Ack-to-rsp_valid latency SHALL be 1 cycle; minimum accept-to-rsp_valid latency SHALL be 2 cycles.
REQ-038 xact_count SHALL increment by 1, wrapping modulo 2^16, on every RESP-to-IDLE transition.
REQ-039 err_count SHALL increment on those transitions only when rsp_err=1, saturating at 255.
REQ-040 rsp_valid SHALL be 0 outside RESP.

Reset
REQ-041 While reset=1, the block SHALL go immediately to IDLE regardless of the clock.
REQ-042 Reset values SHALL be: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, slv_sel=0, slv_write=0, slv_addr=0, slv_wdata=0, timer=0, xact_count=0, err_count=0.
REQ-043 Reset asserted mid-REQ or mid-RESP SHALL abort the transaction with no response and no counter update.

Verification
REQ-044 Write 0x45 <- 0xA5, slave 1 acks in the 3rd REQ cycle -> slv_sel=4'b0010 and slv_write=1 for 3 cycles, slv_wdata=0xA5; then rsp_valid=1, rsp_err=0, rsp_rdata=0; xact_count=1.
REQ-045 Read 0xC0, slave 3 drives 0x5C and acks in the 1st REQ cycle -> rsp_valid 2 cycles after acceptance with rsp_rdata=0x5C.
REQ-046 Read 0x10 with no acks, TIMEOUT=16; slaves 1-3 ack at random -> slv_sel=4'b0001 for exactly 16 cycles, rsp_err=1, rsp_rdata=0, err_count=1.
REQ-047 Selected ack in the same cycle as the timeout condition -> rsp_err=0.
REQ-048 rsp_ready held 0 for 5 cycles with cmd_valid=1 throughout -> rsp_valid, rsp_rdata and rsp_err stable, cmd_ready=0, second command accepted only after return to IDLE.
REQ-049 Reset pulse between clock edges during REQ -> slv_sel=0 and cmd_ready=1 immediately, no response issued, counters unchanged.
